// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode map, sequencer state encoding and IR field helpers for the
// control sequencer slice.
package cpu_ctrl_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_MFHI = 5'd23;
  localparam logic [4:0] OP_MFLO = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT, S_FAULT
  } state_t;

  function automatic logic [4:0] ir_op(input logic [31:0] ir);
    return ir[31:27];
  endfunction

  function automatic logic [3:0] ir_ra(input logic [31:0] ir);
    return ir[26:23];
  endfunction

  function automatic logic [3:0] ir_rb(input logic [31:0] ir);
    return ir[22:19];
  endfunction

  function automatic logic [3:0] ir_rc(input logic [31:0] ir);
    return ir[18:15];
  endfunction

  function automatic logic is_alu_r(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_alu_i(input logic [4:0] op);
    return op inside {OP_ADDI, OP_ANDI, OP_ORI};
  endfunction

  function automatic logic is_mul_div(input logic [4:0] op);
    return op inside {OP_MUL, OP_DIV};
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    return op inside {OP_LD, OP_ST};
  endfunction

  // Immediate forms reuse the ALU operation of their register counterpart.
  function automatic logic [4:0] alu_base(input logic [4:0] op);
    case (op)
      OP_ANDI: return OP_AND;
      OP_ORI:  return OP_OR;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the DataPath/memory side
// (slave): IR and memory handshake in, every enable and strobe out.
interface control_sequencer_if #(
  parameter int REGS = 16,
  parameter int OPW  = 5
);
  logic [31:0]     ir;
  logic            mem_ready;
  logic [REGS-1:0] rin;
  logic [REGS-1:0] rout;
  logic            HIin, LOin, HIout, LOout;
  logic            Zhighout, Zlowout, Zin, Yin;
  logic            MDRout, MDRin, MARin;
  logic            PCout, PCin, IRin, IncPC;
  logic            Cout;
  logic            Read, Write;
  logic [OPW-1:0]  alu_op;
  logic            run;
  logic            fault;

  modport master (
    input  ir, mem_ready,
    output rin, rout, HIin, LOin, HIout, LOout, Zhighout, Zlowout, Zin, Yin,
           MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, Cout, Read, Write,
           alu_op, run, fault
  );

  modport slave (
    output ir, mem_ready,
    input  rin, rout, HIin, LOin, HIout, LOout, Zhighout, Zlowout, Zin, Yin,
           MDRout, MDRin, MARin, PCout, PCin, IRin, IncPC, Cout, Read, Write,
           alu_op, run, fault
  );
endinterface

// File: rtl/control_sequencer_reg_field_decode.sv
// Register-field decoder: turns a 4-bit IR register field into a one-hot
// enable vector, all zero when not enabled.
module reg_field_decode #(
  parameter int REGS = 16
) (
  input  logic                    en,
  input  logic [$clog2(REGS)-1:0] sel,
  output logic [REGS-1:0]         onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Moore control unit for the DataPath: fetch, decode and execute micro-steps,
// one per clock, with a bounded wait on every memory access.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int REGS        = 16,
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                 clock,
  input logic                 clear,
  control_sequencer_if.master bus
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_t          state, next_state;
  logic [CW-1:0]   wait_cnt, cnt_next;
  logic [4:0]      op;
  logic [3:0]      ra, rb, rc;
  logic            mem_wait;
  logic            rin_en, rout_en;
  logic [3:0]      rin_sel, rout_sel;
  logic [REGS-1:0] rin_vec, rout_vec;

  assign op = ir_op(bus.ir);
  assign ra = ir_ra(bus.ir);
  assign rb = ir_rb(bus.ir);
  assign rc = ir_rc(bus.ir);

  reg_field_decode #(.REGS(REGS)) u_rin_dec  (.en(rin_en),  .sel(rin_sel),  .onehot(rin_vec));
  reg_field_decode #(.REGS(REGS)) u_rout_dec (.en(rout_en), .sel(rout_sel), .onehot(rout_vec));

  assign bus.rin  = rin_vec;
  assign bus.rout = rout_vec;

  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= S_RST;
      wait_cnt <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= cnt_next;
    end
  end

  always_comb begin
    next_state   = state;
    cnt_next     = '0;
    mem_wait     = 1'b0;
    rin_en       = 1'b0;
    rin_sel      = ra;
    rout_en      = 1'b0;
    rout_sel     = rb;
    bus.HIin     = 1'b0;
    bus.LOin     = 1'b0;
    bus.HIout    = 1'b0;
    bus.LOout    = 1'b0;
    bus.Zhighout = 1'b0;
    bus.Zlowout  = 1'b0;
    bus.Zin      = 1'b0;
    bus.Yin      = 1'b0;
    bus.MDRout   = 1'b0;
    bus.MDRin    = 1'b0;
    bus.MARin    = 1'b0;
    bus.PCout    = 1'b0;
    bus.PCin     = 1'b0;
    bus.IRin     = 1'b0;
    bus.IncPC    = 1'b0;
    bus.Cout     = 1'b0;
    bus.Read     = 1'b0;
    bus.Write    = 1'b0;
    bus.alu_op   = '0;
    bus.run      = 1'b1;
    bus.fault    = 1'b0;

    case (state)
      S_RST: next_state = S_T0;
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
        next_state = S_T1;
      end
      S_T1: begin
        bus.Zlowout = 1'b1;
        bus.PCin    = 1'b1;
        bus.Read    = 1'b1;
        bus.MDRin   = 1'b1;
        next_state  = bus.mem_ready ? S_T2 : S_T1W;
      end
      // Separate fetch-wait state so the PC update fires exactly once.
      S_T1W: begin
        bus.Read  = 1'b1;
        bus.MDRin = 1'b1;
        mem_wait  = 1'b1;
        if (bus.mem_ready) next_state = S_T2;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
        next_state = S_T3;
      end
      S_T3: begin
        next_state = S_T0;
        if (is_alu_r(op) || is_alu_i(op) || is_mem(op)) begin
          rout_en    = !(is_mem(op) && rb == 4'd0);
          bus.Yin    = 1'b1;
          next_state = S_T4;
        end else if (op == OP_MFHI) begin
          bus.HIout = 1'b1;
          rin_en    = 1'b1;
        end else if (op == OP_MFLO) begin
          bus.LOout = 1'b1;
          rin_en    = 1'b1;
        end else if (op == OP_HALT) begin
          next_state = S_HALT;
        end
      end
      S_T4: begin
        bus.Zin    = 1'b1;
        next_state = S_T5;
        if (is_alu_r(op)) begin
          rout_en    = 1'b1;
          rout_sel   = rc;
          bus.alu_op = OPW'(op);
        end else if (is_alu_i(op)) begin
          bus.Cout   = 1'b1;
          bus.alu_op = OPW'(alu_base(op));
        end else begin
          bus.Cout   = 1'b1;
          bus.alu_op = OPW'(OP_ADD);
        end
      end
      S_T5: begin
        bus.Zlowout = 1'b1;
        next_state  = S_T0;
        if (is_mul_div(op)) begin
          bus.LOin   = 1'b1;
          next_state = S_T6;
        end else if (is_mem(op)) begin
          bus.MARin  = 1'b1;
          next_state = S_T6;
        end else begin
          rin_en = 1'b1;
        end
      end
      S_T6: begin
        next_state = S_T0;
        if (is_mul_div(op)) begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end else if (op == OP_LD) begin
          bus.Read   = 1'b1;
          bus.MDRin  = 1'b1;
          mem_wait   = 1'b1;
          next_state = bus.mem_ready ? S_T7 : S_T6;
        end else begin
          rout_en    = 1'b1;
          rout_sel   = ra;
          bus.MDRin  = 1'b1;
          next_state = S_T7;
        end
      end
      S_T7: begin
        next_state = S_T0;
        if (op == OP_LD) begin
          bus.MDRout = 1'b1;
          rin_en     = 1'b1;
        end else begin
          bus.Write = 1'b1;
          mem_wait  = 1'b1;
          if (!bus.mem_ready) next_state = S_T7;
        end
      end
      S_HALT: bus.run = 1'b0;
      S_FAULT: begin
        bus.run   = 1'b0;
        bus.fault = 1'b1;
      end
      default: next_state = S_RST;
    endcase

    if (mem_wait && !bus.mem_ready) begin
      if (wait_cnt == CW'(MEM_TIMEOUT - 1)) next_state = S_FAULT;
      else cnt_next = wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam int MEM_TIMEOUT = 15;

  localparam logic [17:0] F_NONE   = 18'h00000;
  localparam logic [17:0] F_HIIN   = 18'h00001;
  localparam logic [17:0] F_LOIN   = 18'h00002;
  localparam logic [17:0] F_HIOUT  = 18'h00004;
  localparam logic [17:0] F_LOOUT  = 18'h00008;
  localparam logic [17:0] F_ZHIGH  = 18'h00010;
  localparam logic [17:0] F_ZLOW   = 18'h00020;
  localparam logic [17:0] F_ZIN    = 18'h00040;
  localparam logic [17:0] F_YIN    = 18'h00080;
  localparam logic [17:0] F_MDROUT = 18'h00100;
  localparam logic [17:0] F_MDRIN  = 18'h00200;
  localparam logic [17:0] F_MARIN  = 18'h00400;
  localparam logic [17:0] F_PCOUT  = 18'h00800;
  localparam logic [17:0] F_PCIN   = 18'h01000;
  localparam logic [17:0] F_IRIN   = 18'h02000;
  localparam logic [17:0] F_INCPC  = 18'h04000;
  localparam logic [17:0] F_COUT   = 18'h08000;
  localparam logic [17:0] F_READ   = 18'h10000;
  localparam logic [17:0] F_WRITE  = 18'h20000;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  alu_op;
    logic [17:0] f;
    logic        run;
    logic        fault;
  } outs_t;

  typedef struct {
    logic [31:0] ir;
    logic        mr;
    logic        clr;
    logic        chk;
    outs_t       o;
    string       tag;
  } vec_t;

  localparam outs_t HALT_O  = '{16'h0, 16'h0, 5'd0, 18'h0, 1'b0, 1'b0};
  localparam outs_t FAULT_O = '{16'h0, 16'h0, 5'd0, 18'h0, 1'b0, 1'b1};

  logic  clock;
  logic  clear;
  vec_t  q[$];
  string tag;
  int    checks;
  int    errors;

  control_sequencer_if #(.REGS(16), .OPW(5)) bus ();

  control_sequencer #(.REGS(16), .OPW(5), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] oh(input logic [3:0] r);
    return 16'h0001 << r;
  endfunction

  function automatic outs_t mo(input logic [17:0] f, input logic [15:0] rin = 16'h0,
                               input logic [15:0] rout = 16'h0, input logic [4:0] alu = 5'd0);
    outs_t o;
    o.rin = rin; o.rout = rout; o.alu_op = alu; o.f = f; o.run = 1'b1; o.fault = 1'b0;
    return o;
  endfunction

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rc,
                                        input logic [14:0] imm);
    return {op, ra, rb, rc, imm};
  endfunction

  function automatic void push(input logic [31:0] ir, input outs_t o, input logic mr,
                               input logic clr = 1'b0, input logic chk = 1'b1);
    vec_t v;
    v.ir = ir; v.mr = mr; v.clr = clr; v.chk = chk; v.o = o; v.tag = tag;
    q.push_back(v);
  endfunction

  function automatic void step(input logic [31:0] ir, input outs_t o);
    push(ir, o, 1'($urandom_range(0, 1)));
  endfunction

  function automatic bit access(input logic [31:0] ir, input outs_t first, input outs_t rest,
                                input int w, input bit first_counts);
    int counted = 0;
    for (int c = 0; c < 1000; c++) begin
      push(ir, (c == 0) ? first : rest, (c >= w));
      if (c >= w) return 1'b0;
      if (c > 0 || first_counts) counted++;
      if (counted == MEM_TIMEOUT) return 1'b1;
    end
    return 1'b1;
  endfunction

  function automatic void stuck(input logic [31:0] ir, input outs_t o, input int n);
    for (int i = 0; i < n; i++) step(ir, o);
    push(ir, o, 1'($urandom_range(0, 1)), 1'b1);
    step(ir, mo(F_NONE));
  endfunction

  function automatic void instr(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb,
                                input logic [3:0] rc, input logic [14:0] imm,
                                input int w1, input int w2);
    logic [31:0] ir;
    bit alu_r, alu_i, muldiv;
    logic [4:0] base;
    ir     = mk_ir(op, ra, rb, rc, imm);
    alu_r  = op inside {5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd15, 5'd16};
    alu_i  = op inside {5'd12, 5'd13, 5'd14};
    muldiv = op inside {5'd15, 5'd16};
    base   = (op == 5'd13) ? 5'd5 : (op == 5'd14) ? 5'd6 : 5'd3;

    step(ir, mo(F_PCOUT | F_MARIN | F_INCPC | F_ZIN));
    if (access(ir, mo(F_ZLOW | F_PCIN | F_READ | F_MDRIN), mo(F_READ | F_MDRIN), w1, 1'b0)) begin
      stuck(ir, FAULT_O, 3);
      return;
    end
    step(ir, mo(F_MDROUT | F_IRIN));

    if (alu_r || alu_i) begin
      step(ir, mo(F_YIN, 16'h0, oh(rb)));
      if (alu_r) step(ir, mo(F_ZIN, 16'h0, oh(rc), op));
      else       step(ir, mo(F_COUT | F_ZIN, 16'h0, 16'h0, base));
      if (muldiv) begin
        step(ir, mo(F_ZLOW | F_LOIN));
        step(ir, mo(F_ZHIGH | F_HIIN));
      end else begin
        step(ir, mo(F_ZLOW, oh(ra)));
      end
    end else if (op == 5'd0 || op == 5'd2) begin
      step(ir, mo(F_YIN, 16'h0, (rb == 4'd0) ? 16'h0 : oh(rb)));
      step(ir, mo(F_COUT | F_ZIN, 16'h0, 16'h0, 5'd3));
      step(ir, mo(F_ZLOW | F_MARIN));
      if (op == 5'd0) begin
        if (access(ir, mo(F_READ | F_MDRIN), mo(F_READ | F_MDRIN), w2, 1'b1)) begin
          stuck(ir, FAULT_O, 3);
          return;
        end
        step(ir, mo(F_MDROUT, oh(ra)));
      end else begin
        step(ir, mo(F_MDRIN, 16'h0, oh(ra)));
        if (access(ir, mo(F_WRITE), mo(F_WRITE), w2, 1'b1)) begin
          stuck(ir, FAULT_O, 3);
          return;
        end
      end
    end else if (op == 5'd23) begin
      step(ir, mo(F_HIOUT, oh(ra)));
    end else if (op == 5'd24) begin
      step(ir, mo(F_LOOUT, oh(ra)));
    end else if (op == 5'd27) begin
      step(ir, mo(F_NONE));
      stuck(ir, HALT_O, 20);
    end else begin
      step(ir, mo(F_NONE));
    end
  endfunction

  function automatic outs_t actual();
    outs_t a;
    a.rin    = bus.rin;
    a.rout   = bus.rout;
    a.alu_op = bus.alu_op;
    a.f      = {bus.Write, bus.Read, bus.Cout, bus.IncPC, bus.IRin, bus.PCin, bus.PCout,
                bus.MARin, bus.MDRin, bus.MDRout, bus.Yin, bus.Zin, bus.Zlowout,
                bus.Zhighout, bus.LOout, bus.HIout, bus.LOin, bus.HIin};
    a.run    = bus.run;
    a.fault  = bus.fault;
    return a;
  endfunction

  function automatic int rand_wait();
    return ($urandom_range(0, 19) == 0) ? 20 : int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [31:0] ir_and;
    logic [4:0]  ops[19];
    outs_t       act;
    int          wcnt;
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    bus.ir = '0;
    bus.mem_ready = 1'b0;
    ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd12, 5'd13,
            5'd14, 5'd15, 5'd16, 5'd23, 5'd24, 5'd27, 5'd31, 5'd9, 5'd20};

    tag    = "and_table";
    ir_and = mk_ir(5'd5, 4'd4, 4'd3, 4'd7, 15'd0);
    push(ir_and, mo(F_NONE), 1'b1, 1'b1, 1'b0);
    push(ir_and, mo(F_NONE), 1'b1);
    push(ir_and, mo(F_PCOUT | F_MARIN | F_INCPC | F_ZIN), 1'b1);
    push(ir_and, mo(F_ZLOW | F_PCIN | F_READ | F_MDRIN), 1'b1);
    push(ir_and, mo(F_MDROUT | F_IRIN), 1'b1);
    push(ir_and, mo(F_YIN, 16'h0, 16'h0008), 1'b1);
    push(ir_and, mo(F_ZIN, 16'h0, 16'h0080, 5'd5), 1'b1);
    push(ir_and, mo(F_ZLOW, 16'h0010), 1'b1);
    push(ir_and, mo(F_PCOUT | F_MARIN | F_INCPC | F_ZIN), 1'b1, 1'b1);
    push(ir_and, mo(F_NONE), 1'b1);

    tag = "fetch_wait"; instr(5'd3, 4'd1, 4'd2, 4'd3, 15'd0, 3, 0);
    tag = "mul";        instr(5'd15, 4'd2, 4'd5, 4'd6, 15'd0, 0, 0);
    tag = "ld_r0";      instr(5'd0, 4'd1, 4'd0, 4'd0, 15'h10, 0, 0);
    tag = "ld_wait";    instr(5'd0, 4'd9, 4'd4, 4'd0, 15'd5, 1, 4);
    tag = "st_wait";    instr(5'd2, 4'd3, 4'd2, 4'd0, 15'd4, 0, 2);
    tag = "mfhi";       instr(5'd23, 4'd7, 4'd0, 4'd0, 15'd0, 0, 0);
    tag = "mflo";       instr(5'd24, 4'd15, 4'd0, 4'd0, 15'd0, 0, 0);
    tag = "ori";        instr(5'd14, 4'd8, 4'd11, 4'd1, 15'h7ff, 0, 0);
    tag = "undef31";    instr(5'd31, 4'd5, 4'd5, 4'd5, 15'd0, 0, 0);
    tag = "st_timeout"; instr(5'd2, 4'd3, 4'd2, 4'd0, 15'd4, 0, 40);
    tag = "halt";       instr(5'd27, 4'd0, 4'd0, 4'd0, 15'd0, 0, 0);
    tag = "fetch_tmo";  instr(5'd3, 4'd1, 4'd1, 4'd1, 15'd0, 30, 0);
    tag = "fetch_edge"; instr(5'd4, 4'd6, 4'd14, 4'd13, 15'd0, 15, 0);
    tag = "st_edge";    instr(5'd2, 4'd12, 4'd10, 4'd0, 15'd0, 0, 14);

    tag = "random";
    for (int n = 0; n < 120; n++)
      instr(ops[$urandom_range(0, 18)], 4'($urandom), 4'($urandom), 4'($urandom),
            15'($urandom), rand_wait(), rand_wait());

    foreach (q[i]) begin
      @(negedge clock);
      bus.ir        = q[i].ir;
      bus.mem_ready = q[i].mr;
      clear         = q[i].clr;
      #1;
      if (q[i].chk) begin
        checks++;
        act = actual();
        if (act !== q[i].o) begin
          errors++;
          $display("FAIL %s step %0d: got rin=%h rout=%h alu=%0d flags=%b run=%b fault=%b, want rin=%h rout=%h alu=%0d flags=%b run=%b fault=%b",
                   q[i].tag, i, act.rin, act.rout, act.alu_op, act.f, act.run, act.fault,
                   q[i].o.rin, q[i].o.rout, q[i].o.alu_op, q[i].o.f, q[i].o.run, q[i].o.fault);
        end
      end
    end

    @(negedge clock);
    bus.ir        = mk_ir(5'd2, 4'd3, 4'd2, 4'd0, 15'd4);
    bus.mem_ready = 1'b1;
    clear         = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    #1;
    checks++;
    act = actual();
    if (act !== mo(F_NONE)) begin
      errors++;
      $display("FAIL reset_state: got rin=%h rout=%h alu=%0d flags=%b run=%b fault=%b",
               act.rin, act.rout, act.alu_op, act.f, act.run, act.fault);
    end

    wcnt = 0;
    for (int unsigned c = 0; c < 200 && !bus.fault; c++) begin
      @(negedge clock);
      bus.mem_ready = !bus.Write;
      #1;
      if (bus.Write) wcnt++;
    end
    checks++;
    if (!(bus.fault === 1'b1 && bus.run === 1'b0 && wcnt == MEM_TIMEOUT)) begin
      errors++;
      $display("FAIL expired_wait: fault=%b run=%b write_wait_cycles=%0d want fault=1 run=0 cycles=%0d",
               bus.fault, bus.run, wcnt, MEM_TIMEOUT);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
